// File: rtl/key_matrix_scanner_pkg.sv
// Shared definitions for the key matrix scanner.
//   KEY_CODE_W : width of the key code presented to the consumer
//   key_index  : maps (row, col) to the key code / keys_down bit index
package key_matrix_scanner_pkg;

  localparam int KEY_CODE_W = 4;

  function automatic logic [KEY_CODE_W-1:0] key_index(input int row,
                                                      input int col,
                                                      input int num_cols);
    return KEY_CODE_W'(row * num_cols + col);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer. The counter only advances on this key's column sample.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   sample_en  : one-cycle strobe, this key's column is being sampled
//   raw        : synchronized row level for this key
//   level      : debounced key level
//   rise_pulse : one-cycle pulse the cycle after level goes 0->1
module key_debounce
  import key_matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample_en) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
        // Enough disagreeing samples in a row: accept the new level.
        level_d = ~level_q;
        cnt_d   = '0;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// Push-button matrix scanner: drives one-hot columns, synchronizes and
// debounces every key, and turns debounced presses into single events held
// in a one-entry valid/ack slot.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   COL_SEL   : one-hot column drive
//   ROW_IN    : asynchronous row returns (high = pressed)
//   key_valid : an event is pending
//   key_code  : pending key index (row*NUM_COLS+col), stable while valid
//   key_ack   : consumer accepts the pending event
//   key_lost  : sticky, at least one press event was dropped
//   keys_down : debounced level of every key, bit index = key code
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [NUM_COLS-1:0]            COL_SEL,
  input  logic [NUM_ROWS-1:0]            ROW_IN,
  output logic                           key_valid,
  output logic [KEY_CODE_W-1:0]          key_code,
  input  logic                           key_ack,
  output logic                           key_lost,
  output logic [NUM_ROWS*NUM_COLS-1:0]   keys_down
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int DW_W     = $clog2(SCAN_DIV);

  logic [DW_W-1:0]       dwell_q, dwell_d;
  logic [NUM_COLS-1:0]   col_q, col_d;
  logic [NUM_ROWS-1:0]   row_meta_q, row_sync_q;
  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  lost_q, lost_d;

  logic                  sample_en;
  logic [NUM_KEYS-1:0]   rise;
  logic                  evt_any;
  logic                  evt_multi;
  logic [KEY_CODE_W-1:0] evt_code;
  logic                  slot_load;
  logic                  slot_drop;

  // The last cycle of a column's dwell is its sample point, giving the rows
  // time to settle and pass through the synchronizer.
  assign sample_en = (dwell_q == DW_W'(SCAN_DIV - 1));

  always_comb begin
    dwell_d = dwell_q + 1'b1;
    col_d   = col_q;
    if (sample_en) begin
      dwell_d = '0;
      col_d   = (col_q << 1) | (col_q >> (NUM_COLS - 1));
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en & col_q[c]),
        .raw       (row_sync_q[r]),
        .level     (keys_down[r*NUM_COLS+c]),
        .rise_pulse(rise[r*NUM_COLS+c])
      );
    end
  end

  // All rises in one cycle come from the same column. Walking rows from the
  // top down lets the lowest row overwrite, so it wins; a second hit marks
  // that the other events are being dropped.
  always_comb begin
    evt_any   = 1'b0;
    evt_multi = 1'b0;
    evt_code  = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (rise[r*NUM_COLS+c]) begin
          if (evt_any) evt_multi = 1'b1;
          evt_any  = 1'b1;
          evt_code = key_index(r, c, NUM_COLS);
        end
      end
    end
  end

  assign slot_load = evt_any && (!valid_q || key_ack);
  assign slot_drop = evt_multi || (evt_any && valid_q && !key_ack);

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    lost_d  = lost_q;
    if (slot_load) begin
      valid_d = 1'b1;
      code_d  = evt_code;
    end else if (key_ack && valid_q) begin
      valid_d = 1'b0;
    end
    // A drop in the same cycle as an ack keeps the flag set.
    if (slot_drop) begin
      lost_d = 1'b1;
    end else if (key_ack && valid_q) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q    <= '0;
      col_q      <= NUM_COLS'(1);
      row_meta_q <= '0;
      row_sync_q <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      lost_q     <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      row_meta_q <= ROW_IN;
      row_sync_q <= row_meta_q;
      valid_q    <= valid_d;
      code_q     <= code_d;
      lost_q     <= lost_d;
    end
  end

  assign COL_SEL   = col_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_lost  = lost_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
module tb_key_matrix_scanner;

  localparam int NC = 4;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] col_sel;
  logic [NR-1:0] row_in;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_ack;
  logic          key_lost;
  logic [15:0]   keys_down;

  logic [15:0]   pressed;
  logic [3:0]    sb_q[$];
  logic          prev_valid;
  int            n_checks = 0;
  int            n_errors = 0;

  key_matrix_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_DIV(4), .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk), .rst(rst), .COL_SEL(col_sel), .ROW_IN(row_in),
    .key_valid(key_valid), .key_code(key_code), .key_ack(key_ack),
    .key_lost(key_lost), .keys_down(keys_down)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads high when a pressed key sits in a driven column.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < NR; r++) row_in[r] = |(pressed[r*NC +: NC] & col_sel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!key_valid && i < budget) begin
      tick(1);
      i++;
    end
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
  endtask

  // Leaves the bench on the first negedge of column 0, dwell 0.
  task automatic align_frame();
    logic [NC-1:0] prev;
    for (int i = 0; i < 40; i++) begin
      prev = col_sel;
      tick(1);
      if (prev == 4'b1000 && col_sel == 4'b0001) return;
    end
    chk("align_timeout", 32'(col_sel), 32'h1);
  endtask

  // Scoreboard: every rising key_valid must match the oldest expected code.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && key_valid && !prev_valid) begin
      chk("evt_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) chk("evt_code", 32'(key_code), 32'(sb_q.pop_front()));
    end
    prev_valid = key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_ack = 1'b0;
    pressed = '0;
    tick(3);
    rst = 1'b0;

    // 1: reset state and idle column rotation (n = 0)
    chk("rst_col", 32'(col_sel), 32'h1);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_lost", 32'(key_lost), 32'd0);
    chk("rst_down", 32'(keys_down), 32'd0);
    tick(3);
    chk("col_dwell_end", 32'(col_sel), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("col_rot", 32'(col_sel), 32'((4'b0001 << (k % 4)) | (4'b0001 >> (4 - (k % 4)))));
      if (k < 4) tick(3);
    end
    chk("idle_down", 32'(keys_down), 32'd0);
    chk("idle_valid", 32'(key_valid), 32'd0);

    // 2: steady press of key 6 (row 1, col 2), from n = 16
    pressed[6] = 1'b1;
    sb_q.push_back(4'd6);
    tick(27);
    chk("t2_down_before", 32'(keys_down[6]), 32'd0);
    tick(1);
    chk("t2_down_rise", 32'(keys_down[6]), 32'd1);
    chk("t2_valid_lag", 32'(key_valid), 32'd0);
    tick(1);
    chk("t2_valid", 32'(key_valid), 32'd1);
    chk("t2_code", 32'(key_code), 32'd6);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t2_ack_clear", 32'(key_valid), 32'd0);
    pressed[6] = 1'b0;
    tick(29);
    chk("t2_release_hold", 32'(keys_down[6]), 32'd1);
    tick(1);
    chk("t2_release", 32'(keys_down[6]), 32'd0);
    tick(4);
    chk("t2_no_release_evt", 32'(key_valid), 32'd0);

    // 3: key 6 bouncing on every column-2 sample, from n = 80
    for (int f = 0; f < 5; f++) begin
      tick(8);
      pressed[6] = (f % 2 == 0);
      tick(8);
      chk("t3_bounce_down", 32'(keys_down[6]), 32'd0);
    end
    pressed[6] = 1'b0;
    tick(16);
    chk("t3_down_end", 32'(keys_down), 32'd0);
    chk("t3_valid_end", 32'(key_valid), 32'd0);

    // 4: second press while the slot is full is dropped
    pressed[6] = 1'b1;
    sb_q.push_back(4'd6);
    wait_valid("t4_first", 64);
    pressed[9] = 1'b1;
    tick(40);
    chk("t4_down9", 32'(keys_down[9]), 32'd1);
    chk("t4_valid_held", 32'(key_valid), 32'd1);
    chk("t4_code_held", 32'(key_code), 32'd6);
    chk("t4_lost", 32'(key_lost), 32'd1);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t4_ack_valid", 32'(key_valid), 32'd0);
    chk("t4_ack_lost", 32'(key_lost), 32'd0);
    pressed = '0;
    tick(48);
    chk("t4_released", 32'(keys_down), 32'd0);

    // 5: keys 2 and 14 rise in the same sample, lowest row wins
    align_frame();
    pressed[2] = 1'b1;
    pressed[14] = 1'b1;
    sb_q.push_back(4'd2);
    wait_valid("t5", 64);
    chk("t5_code", 32'(key_code), 32'd2);
    chk("t5_lost", 32'(key_lost), 32'd1);
    chk("t5_down", 32'(keys_down & 16'h4004), 32'h4004);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t5_ack_valid", 32'(key_valid), 32'd0);
    chk("t5_ack_lost", 32'(key_lost), 32'd0);
    pressed = '0;
    tick(48);

    // 6: reset mid-dwell with an event pending and key_lost set
    align_frame();
    pressed[2] = 1'b1;
    pressed[14] = 1'b1;
    sb_q.push_back(4'd2);
    wait_valid("t6", 64);
    chk("t6_lost_pre", 32'(key_lost), 32'd1);
    tick(1);
    rst = 1'b1;
    pressed = '0;
    tick(1);
    rst = 1'b0;
    chk("t6_valid", 32'(key_valid), 32'd0);
    chk("t6_down", 32'(keys_down), 32'd0);
    chk("t6_col", 32'(col_sel), 32'h1);
    chk("t6_lost", 32'(key_lost), 32'd0);
    chk("t6_code", 32'(key_code), 32'd0);
    tick(40);
    chk("t6_quiet", 32'(key_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
